icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 132 +++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines sitting between the
// decoder fetch port and the memory controller; misses block until refilled.
module icache #(
   parameter int IDX_WIDTH = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        if_enable,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] inst,
   output logic        mem_if_enable,
   output logic [31:0] mem_if_addr,
   input  logic        mem_if_ready,
   input  logic [31:0] mem_inst
);

   localparam int LINES = 1 << IDX_WIDTH;
   localparam int TAG_W = 16 - IDX_WIDTH;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                if_ready_q, if_ready_d;
   logic [31:0]         inst_q, inst_d;
   logic                mem_en_q, mem_en_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   logic [IDX_WIDTH-1:0] req_idx_s, fill_idx_s;
   logic [TAG_W-1:0]     req_tag_s, fill_tag_s;
   logic                 hit_s, accept_s, fill_s;
   logic                 unused_bits_s;

   assign req_idx_s  = if_addr[IDX_WIDTH+1:2];
   assign req_tag_s  = if_addr[17:IDX_WIDTH+2];
   assign fill_idx_s = mem_addr_q[IDX_WIDTH+1:2];
   assign fill_tag_s = mem_addr_q[17:IDX_WIDTH+2];
   assign hit_s      = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
   // A request still visible while if_ready is high is the one just served.
   assign accept_s   = (state_q == IDLE) && if_enable && !if_ready_q && !clear;
   assign unused_bits_s = ^{if_addr[1:0], mem_addr_q[1:0], mem_addr_q[31:18]};

   assign if_ready      = if_ready_q;
   assign inst          = inst_q;
   assign mem_if_enable = mem_en_q;
   assign mem_if_addr   = mem_addr_q;

   always_comb begin
      state_d    = state_q;
      if_ready_d = 1'b0;
      inst_d     = inst_q;
      mem_en_d   = mem_en_q;
      mem_addr_d = mem_addr_q;
      fill_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (hit_s) begin
                  if_ready_d = 1'b1;
                  inst_d     = data_q[req_idx_s];
               end else begin
                  state_d    = MISS;
                  mem_en_d   = 1'b1;
                  mem_addr_d = {if_addr[31:2], 2'b00};
               end
            end else begin
               state_d = IDLE;
            end
         end
         MISS: begin
            // The returned word is kept even when flushed; only the reply is dropped.
            if (mem_if_ready) begin
               fill_s   = 1'b1;
               state_d  = IDLE;
               mem_en_d = 1'b0;
               if (!clear) begin
                  if_ready_d = 1'b1;
                  inst_d     = mem_inst;
               end else begin
                  if_ready_d = 1'b0;
               end
            end else if (clear) begin
               state_d  = IDLE;
               mem_en_d = 1'b0;
            end else begin
               state_d = MISS;
            end
         end
         default: begin
            state_d  = IDLE;
            mem_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         if_ready_q <= 1'b0;
         inst_q     <= 32'd0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= 32'd0;
         valid_q    <= '0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         if_ready_q <= if_ready_d;
         inst_q     <= inst_d;
         mem_en_q   <= mem_en_d;
         mem_addr_q <= mem_addr_d;
         if (fill_s) begin
            valid_q[fill_idx_s] <= 1'b1;
         end
      end
   end

   // Tag and data storage need no reset; the valid bits gate every use.
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && fill_s) begin
         tag_q[fill_idx_s]  <= fill_tag_s;
         data_q[fill_idx_s] <= mem_inst;
      end
   end

endmodule
